// File: rtl/int_fma_unit.sv
// int_fma_unit: integer fused multiply-add/accumulate engine.
// fmaOut = (mulIn1 * mulIn2) +/- addend, with runtime signed/unsigned mode and
// an internal accumulator that can replace addIn as the addend.
// A radix-2 shift-add multiplier works on operand magnitudes, one bit per cycle.
// It is followed by a single add cycle. The result is held until the consumer takes it.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready are
// both high. inReady is high only in IDLE. outValid is high only in DONE, and
// fmaOut stays stable until outReady is seen. Inputs that arrive while the
// matching ready (or valid) is low are ignored and never queued.
module int_fma_unit #(
  parameter int WIDTH    = 11,
  parameter int OUTWIDTH = 2 * WIDTH + 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                inValid,
  output logic                inReady,
  input  logic [WIDTH-1:0]    mulIn1,
  input  logic [WIDTH-1:0]    mulIn2,
  input  logic [WIDTH-1:0]    addIn,
  input  logic                signedMode,
  input  logic                negAdd,
  input  logic                accumulate,
  input  logic                clearAcc,
  output logic                outValid,
  input  logic                outReady,
  output logic [OUTWIDTH-1:0] fmaOut
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]       CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]       CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0]    ONE_W    = WIDTH'(1);
  localparam logic [OUTWIDTH-1:0] ONE_O    = OUTWIDTH'(1);

  // The result must hold the full signed product plus one bit for the addend.
  if (OUTWIDTH < 2 * WIDTH + 1) begin : g_bad_outwidth
    $error("int_fma_unit: OUTWIDTH must be at least 2*WIDTH+1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [PW-1:0]        mcand_q, mcand_d;    // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]     mplier_q, mplier_d;  // multiplier magnitude, shifted right each step
  logic [PW-1:0]        prod_q, prod_d;      // unsigned partial product
  logic                 neg_prod_q, neg_prod_d;
  logic                 neg_add_q, neg_add_d;
  logic                 use_acc_q, use_acc_d;
  logic [OUTWIDTH-1:0]  addend_q, addend_d;
  logic [OUTWIDTH-1:0]  acc_q, acc_d;
  logic [OUTWIDTH-1:0]  fma_q, fma_d;
  logic [OUTWIDTH-1:0]  sum_w;

  // Magnitude of an operand. The most negative value maps to 2^(WIDTH-1),
  // which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + ONE_W) : v;
  endfunction

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prod_q     <= '0;
      neg_prod_q <= 1'b0;
      neg_add_q  <= 1'b0;
      use_acc_q  <= 1'b0;
      addend_q   <= '0;
      acc_q      <= '0;
      fma_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prod_q     <= prod_d;
      neg_prod_q <= neg_prod_d;
      neg_add_q  <= neg_add_d;
      use_acc_q  <= use_acc_d;
      addend_q   <= addend_d;
      acc_q      <= acc_d;
      fma_q      <= fma_d;
    end
  end

  // Next-state logic: IDLE -> MUL (WIDTH steps) -> ADD -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (inValid) state_d = S_MUL;
      S_MUL:  if (cnt_q == CNT_LAST) state_d = S_ADD;
      S_ADD:  state_d = S_DONE;
      S_DONE: if (outReady) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    inReady  = (state_q == S_IDLE);
    outValid = (state_q == S_DONE);
    fmaOut   = fma_q;
  end

  // Final sum: sign-fix the product, widen it, then add or subtract the addend.
  always_comb begin
    logic [OUTWIDTH-1:0] prod_ext;
    logic [OUTWIDTH-1:0] prod_signed;
    logic [OUTWIDTH-1:0] addend_sel;
    prod_ext    = {{(OUTWIDTH - PW){1'b0}}, prod_q};
    prod_signed = neg_prod_q ? (~prod_ext + ONE_O) : prod_ext;
    addend_sel  = use_acc_q ? acc_q : addend_q;
    sum_w       = neg_add_q ? (prod_signed - addend_sel) : (prod_signed + addend_sel);
  end

  // Datapath updates: operand capture at accept, shift-add in MUL, result in ADD.
  always_comb begin
    cnt_d      = cnt_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prod_d     = prod_q;
    neg_prod_d = neg_prod_q;
    neg_add_d  = neg_add_q;
    use_acc_d  = use_acc_q;
    addend_d   = addend_q;
    acc_d      = acc_q;
    fma_d      = fma_q;
    case (state_q)
      S_IDLE: begin
        // Clearing here also covers an accept in the same cycle: that op then
        // reads a zero accumulator in its ADD cycle.
        if (clearAcc) acc_d = '0;
        if (inValid) begin
          cnt_d      = '0;
          mcand_d    = {{WIDTH{1'b0}}, magnitude(mulIn1, signedMode)};
          mplier_d   = magnitude(mulIn2, signedMode);
          prod_d     = '0;
          neg_prod_d = signedMode & (mulIn1[WIDTH-1] ^ mulIn2[WIDTH-1]);
          neg_add_d  = negAdd;
          use_acc_d  = accumulate;
          addend_d   = {{(OUTWIDTH - WIDTH){signedMode & addIn[WIDTH-1]}}, addIn};
        end
      end
      S_MUL: begin
        if (mplier_q[0]) prod_d = prod_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_ONE;
      end
      S_ADD: begin
        fma_d = sum_w;
        acc_d = sum_w;
      end
      default: begin
      end
    endcase
  end

endmodule
